clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
//-----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable burst clock divider. An accepted start latches a half-period
// divisor and a burst length, then generates out_clk with a period of
// 2*div clk cycles. The run ends after `burst` complete periods (0 means run
// until stopped) or on a stop request. A stop that arrives while out_clk is
// high drains the current period so out_clk never produces a short high
// pulse.
//
// Optional feature: define CLK_DIV_CTRL_OUT_N_EN to add out_clk_n, a
// registered complement of out_clk (1 in reset and IDLE).
//
// Ports
//   clk        in   sole clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle run request (accepted in IDLE when div != 0)
//   stop       in   single-cycle abort request (honoured in RUN only)
//   div        in   [DIV_W] half-period in clk cycles, sampled on accepted start
//   burst      in   [CNT_W] periods to generate, 0 = free-running
//   out_clk    out  divided clock, straight from a flop
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle pulse on return to IDLE
//   period_cnt out  [CNT_W] completed out_clk periods since the last start
//   out_clk_n  out  complement of out_clk (only with CLK_DIV_CTRL_OUT_N_EN)
//-----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst,
    output logic             out_clk,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_cnt
`ifdef CLK_DIV_CTRL_OUT_N_EN
    ,
    output logic             out_clk_n
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] phase, phase_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [CNT_W-1:0] burst_q, burst_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_nxt;
    logic             done_nxt;

    // Free-running advance of the divider, used by both RUN and DRAIN.
    logic             phase_wrap;
    logic [DIV_W-1:0] adv_phase;
    logic             adv_out;
    logic             fall;
    logic [CNT_W-1:0] cnt_inc;

    assign phase_wrap = (phase == (div_q - DIV_W'(1)));
    assign adv_phase  = phase_wrap ? '0 : (phase + DIV_W'(1));
    assign adv_out    = phase_wrap ? ~out_clk : out_clk;
    // A falling edge of out_clk closes one full period.
    assign fall       = phase_wrap & out_clk;
    assign cnt_inc    = period_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        out_nxt   = out_clk;
        cnt_nxt   = period_cnt;
        div_nxt   = div_q;
        burst_nxt = burst_q;
        done_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                // stop is ignored here; start wins even when both are high.
                if (start && (div != '0)) begin
                    state_nxt = RUN;
                    phase_nxt = '0;
                    out_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    div_nxt   = div;
                    burst_nxt = burst;
                end
            end

            RUN: begin
                if (stop && !out_clk) begin
                    // Output already low: finish immediately, no further edge.
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    phase_nxt = adv_phase;
                    out_nxt   = adv_out;
                    if (fall) begin
                        cnt_nxt = cnt_inc;
                    end
                    // A stop that coincides with the falling edge needs no drain.
                    if (fall && (stop || ((burst_q != '0) && (cnt_inc == burst_q)))) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (stop) begin
                        state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                phase_nxt = adv_phase;
                out_nxt   = adv_out;
                if (fall) begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            div_q      <= '0;
            burst_q    <= '0;
            out_clk    <= 1'b0;
            period_cnt <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            div_q      <= div_nxt;
            burst_q    <= burst_nxt;
            out_clk    <= out_nxt;
            period_cnt <= cnt_nxt;
            done       <= done_nxt;
        end
    end

    assign busy = (state != IDLE);

`ifdef CLK_DIV_CTRL_OUT_N_EN
    // Own flop fed from the same next value, so it is a clean complement
    // rather than an inverter after out_clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clk_n <= 1'b1;
        end else begin
            out_clk_n <= ~out_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    localparam int DIV_W = 8;
    localparam int CNT_W = 16;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst;
    logic             out_clk;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period_cnt;
`ifdef CLK_DIV_CTRL_OUT_N_EN
    logic             out_clk_n;
`endif

    clk_div_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .div        (div),
        .burst      (burst),
        .out_clk    (out_clk),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
`ifdef CLK_DIV_CTRL_OUT_N_EN
        ,
        .out_clk_n  (out_clk_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the run is described by k, the number of clk edges
    // since the accepted start. out_clk is high in odd blocks of div cycles,
    // and each block pair of 2*div cycles is one completed period.
    int m_mode;   // 0 idle, 1 run, 2 drain
    int m_k;
    int m_div;
    int m_burst;
    int m_cnt;
    bit m_out;
    bit m_done;

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_div = 0; m_burst = 0;
        m_cnt = 0; m_out = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit was_run;
        bit is_fall;
        m_done  = 0;
        was_run = (m_mode == 1);
        if (m_mode == 0) begin
            if (start && div != 0) begin
                m_mode = 1; m_k = 0; m_div = int'(div); m_burst = int'(burst);
                m_out = 0; m_cnt = 0;
            end
        end else if (was_run && stop && !m_out) begin
            m_mode = 0;
            m_done = 1;
        end else begin
            m_k++;
            m_out   = ((m_k / m_div) % 2) == 1;
            m_cnt   = (m_k / (2 * m_div)) % CNT_MOD;
            is_fall = (m_k % (2 * m_div)) == 0;
            if (is_fall && (m_mode == 2 || (was_run && stop) ||
                            (m_burst != 0 && m_cnt == m_burst))) begin
                m_mode = 0;
                m_done = 1;
            end else if (was_run && stop) begin
                m_mode = 2;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out_clk"}, 32'(out_clk), 32'(m_out));
        chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".period_cnt"}, 32'(period_cnt), 32'(m_cnt));
`ifdef CLK_DIV_CTRL_OUT_N_EN
        chk({tag, ".out_clk_n"}, 32'(out_clk_n), 32'(!m_out));
`endif
    endtask

    // One clock edge: model consumes the same pre-edge inputs as the DUT,
    // outputs are sampled 1 time unit after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        rst_n = 1'b1; start = 0; stop = 0; div = '0; burst = '0;
        model_reset();
        #2;
        do_reset("rst0");

        // div=3, burst=4: 24 clk edges then done.
        div = 8'd3; burst = 16'd4; start = 1;
        tick("s1_start");
        start = 0; div = 8'd7; burst = 16'd1;   // must not affect the run
        n = 0;
        while (!done && n < 100) begin
            tick("s1_run");
            n++;
        end
        chk("s1_len", 32'(n), 32'd24);
        chk("s1_cnt", 32'(period_cnt), 32'd4);
        tick("s1_after");
        chk("s1_busy_low", 32'(busy), 32'd0);
        chk("s1_cnt_hold", 32'(period_cnt), 32'd4);

        // div=2 free-running, stop while out_clk high -> drain.
        div = 8'd2; burst = 16'd0; start = 1;
        tick("s2_start");
        start = 0;
        n = 0;
        while (!(out_clk && period_cnt == 1) && n < 100) begin tick("s2_run"); n++; end
        chk("s2_reach_high", 32'(out_clk), 32'd1);
        stop = 1;
        tick("s2_stop");
        stop = 0;
        chk("s2_draining", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin tick("s2_drain"); n++; end
        chk("s2_final_cnt", 32'(period_cnt), 32'd2);
        chk("s2_out_low", 32'(out_clk), 32'd0);

        // div=0 start is ignored.
        div = 8'd0; burst = 16'd3; start = 1;
        tick("s3_div0");
        start = 0;
        chk("s3_busy", 32'(busy), 32'd0);
        tick("s3_idle");

        // start+stop in IDLE -> runs; start+stop in RUN -> stop taken.
        div = 8'd1; burst = 16'd0; start = 1; stop = 1;
        tick("s4_both_idle");
        start = 0; stop = 0;
        chk("s4_running", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) tick("s4_run");
        start = 1; stop = 1;
        tick("s4_both_run");
        start = 0; stop = 0;
        n = 0;
        while (busy && n < 10) begin tick("s4_end"); n++; end
        chk("s4_stopped", 32'(busy), 32'd0);

        // Reset mid-run with out_clk high, then restart with div=5.
        div = 8'd4; burst = 16'd0; start = 1;
        tick("s5_start");
        start = 0;
        n = 0;
        while (!(out_clk && period_cnt == 1) && n < 100) begin tick("s5_run"); n++; end
        do_reset("s5_rst");
        chk("s5_out0", 32'(out_clk), 32'd0);
        chk("s5_busy0", 32'(busy), 32'd0);
        chk("s5_cnt0", 32'(period_cnt), 32'd0);
        div = 8'd5; burst = 16'd2; start = 1;
        tick("s5_restart");
        start = 0;
        n = 0;
        while (!done && n < 100) begin tick("s5_run2"); n++; end
        chk("s5_len", 32'(n), 32'd20);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 14) == 0);
            div   = DIV_W'($urandom_range(0, 4));
            burst = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
